// File: rtl/montgomery_param_mult.sv
// montgomery_param_mult: iterative radix-2^DIGITS Montgomery multiplier, result = A*B*2^-WIDTH mod M
module montgomery_param_mult #(
   parameter int WIDTH  = 1024,
   parameter int DIGITS = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);
   localparam int STEPS = WIDTH / DIGITS;
   localparam int CW    = $clog2(STEPS + 1);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOOP = 2'd1;
   localparam logic [1:0] S_SUB  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
   logic [WIDTH+1:0] c_q, c_d, c_step;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;

   // DIGITS chained radix-2 steps; C stays below 2M so WIDTH+2 bits never overflow
   always_comb begin
      c_step = c_q;
      for (int j = 0; j < DIGITS; j++) begin
         c_step = c_step + (a_q[j] ? {2'b00, b_q} : '0);
         c_step = (c_step + (c_step[0] ? {2'b00, m_q} : '0)) >> 1;
      end
   end

   // Control FSM and datapath next-state
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            a_d     = in_a;
            b_d     = in_b;
            m_d     = in_m;
            c_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_LOOP;
         end
         S_LOOP: begin
            c_d     = c_step;
            a_d     = a_q >> DIGITS;
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == LAST) ? S_SUB : S_LOOP;
         end
         S_SUB: begin
            result_d = (c_q < {2'b00, m_q}) ? c_q[WIDTH-1:0] : c_q[WIDTH-1:0] - m_q;
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers, cleared immediately on reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         c_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         m_q      <= m_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;
endmodule

// File: tb/tb_montgomery_param_mult.sv
// tb_montgomery_param_mult: scoreboard bench for WIDTH=8 with DIGITS=1,2,4 side by side
module tb_montgomery_param_mult;
   localparam int W = 8;
   typedef struct {
      logic [W-1:0] res;
      int           scyc;
   } exp_t;

   logic         clk = 1'b0, resetn = 1'b0, start = 1'b0;
   logic [W-1:0] in_a = '0, in_b = '0, in_m = 8'd1;
   logic [W-1:0] result [3];
   logic         busy [3];
   logic         done [3];
   exp_t         exp_q[$];
   int           rd [3] = '{0, 0, 0};
   int           tests = 0, fails = 0, cyc = 0;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         montgomery_param_mult #(.WIDTH(W), .DIGITS((g == 0) ? 1 : (g == 1) ? 2 : 4)) dut (
            .clk(clk), .resetn(resetn), .start(start), .in_a(in_a), .in_b(in_b), .in_m(in_m),
            .result(result[g]), .busy(busy[g]), .done(done[g]));
      end
   endgenerate

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   // Monitor: every done pulse consumes the next expectation for that DUT
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (resetn && done[i]) begin
            if (rd[i] >= exp_q.size()) begin
               chk($sformatf("unexpected_done_dut%0d", i), 1, 0);
            end else begin
               e = exp_q[rd[i]];
               rd[i]++;
               chk($sformatf("result_dut%0d_txn%0d", i, rd[i]), int'(result[i]), int'(e.res));
               chk($sformatf("latency_dut%0d_txn%0d", i, rd[i]), cyc - e.scyc, (i == 0) ? 10 : (i == 1) ? 6 : 4);
               chk($sformatf("busy_at_done_dut%0d", i), int'(busy[i]), 1);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy[0] || busy[1] || busy[2]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", n, 0);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m, input logic [W-1:0] r);
      wait_idle();
      in_a = a;
      in_b = b;
      in_m = m;
      start = 1'b1;
      exp_q.push_back('{r, cyc});
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) chk($sformatf("busy_after_accept_dut%0d", i), int'(busy[i]), 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((busy[0] || busy[1] || busy[2] || rd[0] < exp_q.size() || rd[1] < exp_q.size() || rd[2] < exp_q.size()) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("drain_timeout", n, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_result_dut%0d", i), int'(result[i]), 0);
         chk($sformatf("reset_busy_dut%0d", i), int'(busy[i]), 0);
         chk($sformatf("reset_done_dut%0d", i), int'(done[i]), 0);
      end
      resetn = 1'b1;
      @(negedge clk);
      issue(8'd1, 8'd1, 8'd13, 8'd3);
      issue(8'd9, 8'd5, 8'd13, 8'd5);
      issue(8'd12, 8'd12, 8'd13, 8'd3);
      issue(8'd0, 8'd7, 8'd13, 8'd0);
      issue(8'd5, 8'd7, 8'd251, 8'd7);
      issue(8'd250, 8'd250, 8'd251, 8'd201);
      issue(8'd2, 8'd3, 8'd251, 8'd202);
      issue(8'd0, 8'd123, 8'd251, 8'd0);
      issue(8'd200, 8'd100, 8'd255, 8'd110);
      issue(8'd254, 8'd254, 8'd255, 8'd1);
      issue(8'd2, 8'd2, 8'd3, 8'd1);
      issue(8'd100, 8'd200, 8'd251, 8'd235);
      in_a = 8'd5;
      in_b = 8'd7;
      in_m = 8'd13;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      wait_idle();
      in_a = 8'd9;
      in_b = 8'd9;
      in_m = 8'd13;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("midloop_reset_result_dut%0d", i), int'(result[i]), 0);
         chk($sformatf("midloop_reset_busy_dut%0d", i), int'(busy[i]), 0);
      end
      resetn = 1'b1;
      repeat (15) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("post_reset_result_dut%0d", i), int'(result[i]), 0);
         chk($sformatf("pending_dut%0d", i), rd[i], exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end
endmodule
